out_fifo_arbiter: RTL and testbench
===================================

OUT_FIFO_ARBITER -- requirements
Module: out_fifo_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning consecutive stalled cycles while granted before the grant is revoked.
REQ-002 SHALL have port clk_24576000_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid_i / req1_valid_i, input, 1 each, requester byte valid.
REQ-005 SHALL have ports req0_data_i / req1_data_i, input, 8 each, requester byte; the first byte of a packet is the header {cmd[1:0], len[5:0]}.
REQ-006 SHALL have ports req0_last_i / req1_last_i, input, 1 each, marking the final byte of a packet.
REQ-007 SHALL have ports req0_ready_o / req1_ready_o, output, 1 each, byte accepted when valid and ready are both high.
REQ-008 SHALL have port wr_out_fifo_clk_o, output, 1, equal to clk_24576000_i.
REQ-009 SHALL have ports wr_out_fifo_en_o (output, 1) and wr_out_fifo_data_o (output, 8), the OUT FIFO write strobe and byte.
REQ-010 SHALL have ports wr_out_fifo_full_i and wr_out_fifo_afull_i, input, 1 each, OUT FIFO full and almost-full flags.
REQ-011 SHALL have port timeout_o, output, 1, a one-cycle pulse when a grant is revoked by the watchdog.
REQ-012 SHALL have port len_err_o, output, 1, a one-cycle pulse on packet length mismatch (see Configuration).

Function
REQ-013 SHALL use the states IDLE and XFER, plus an owner register (0/1) and a last_owner register.
REQ-014 In IDLE with exactly one valid request, SHALL grant that requester and enter XFER on the next edge.
REQ-015 In IDLE with both requests valid, SHALL grant the requester that is not last_owner (round robin).
REQ-016 reqN_ready_o SHALL be combinational and high only when the state is XFER, owner==N, wr_out_fifo_full_i is low and wr_out_fifo_afull_i is low; the non-owner's ready SHALL be low.
REQ-017 On an accepted byte, SHALL drive wr_out_fifo_en_o=1 with wr_out_fifo_data_o=byte on the following cycle (one-cycle latency); otherwise wr_out_fifo_en_o SHALL be 0 and the data SHALL hold.
REQ-018 SHALL never write while wr_out_fifo_full_i or wr_out_fifo_afull_i is high; a packet stalls mid-stream and resumes without losing or duplicating bytes.
REQ-019 On acceptance of a byte with last=1, SHALL set last_owner=owner and return to IDLE; a new grant is possible on the next cycle (one idle cycle between packets).
REQ-020 Grant changes SHALL occur only on packet boundaries or on timeout; the owner's packet is never interleaved.
REQ-021 Watchdog: a 16-bit counter SHALL increment each XFER cycle in which the owner's valid is low, clear on every accepted byte, and not count FIFO-full stalls.
REQ-022 When the watchdog counter reaches TIMEOUT_CYCLES, SHALL pulse timeout_o for one cycle, set last_owner=owner and return to IDLE.

Reset
REQ-023 While reset_n_i is low, SHALL force: state=IDLE, last_owner=1 (requester 0 wins the first tie), wr_out_fifo_en_o=0, wr_out_fifo_data_o=8'h00, timeout_o=0, len_err_o=0, all counters 0.
REQ-024 Reset asserted mid-packet SHALL abandon the packet; no write SHALL occur in the cycle after reset deassertion.

Configuration
REQ-025 With macro OUT_ARB_LEN_CHECK_EN defined, SHALL latch len[5:0] from the header, count the payload bytes accepted, and pulse len_err_o for one cycle when a last byte is accepted with payload count != len; the packet SHALL still be forwarded unchanged.
REQ-026 Without OUT_ARB_LEN_CHECK_EN, len_err_o SHALL be tied to 0 and no length counter SHALL exist.

Verification
REQ-027 Req0 sends 8'h41, 8'hAB (last), FIFO not full -> FIFO writes 41 then AB on consecutive cycles, one cycle after each accept.
REQ-028 Both requesters valid from reset, each sending 2-byte packets -> order is req0, req1, req0, req1, with no interleaved bytes.
REQ-029 afull high for 5 cycles mid-packet -> both readies low, no writes during those cycles, remaining bytes written after afull drops, none lost.
REQ-030 Req1 granted, then valid low for 255 cycles -> timeout_o pulses once, state returns to IDLE, a pending req0 is granted next.
REQ-031 With OUT_ARB_LEN_CHECK_EN, header 8'h42 followed by 1 payload byte with last -> len_err_o pulses once; header 8'h41 followed by 1 payload byte -> no pulse.
REQ-032 reset_n_i low for 2 cycles mid-packet -> wr_out_fifo_en_o=0 immediately, state IDLE, next grant goes to req0 on a tie.

Source files
------------

// File: rtl/out_fifo_arbiter.sv
// Two-requester round-robin packet arbiter feeding an OUT FIFO, with a stall watchdog.
// Define OUT_ARB_LEN_CHECK_EN to enable header length checking on len_err_o.
module out_fifo_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_24576000_i,
    input  logic       reset_n_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    output logic       wr_out_fifo_clk_o,
    output logic       wr_out_fifo_en_o,
    output logic [7:0] wr_out_fifo_data_o,
    input  logic       wr_out_fifo_full_i,
    input  logic       wr_out_fifo_afull_i,
    output logic       timeout_o,
    output logic       len_err_o
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WD_W   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_timeout;

    logic              w_xfer_ok;
    logic              w_own_valid;
    logic              w_own_last;
    logic [DATA_W-1:0] w_own_data;
    logic              w_accept;
    logic [WD_W-1:0]   w_wd_inc;
    logic              w_wd_expire;

    // Either FIFO flag blocks the owner so a packet stalls in place.
    assign w_xfer_ok   = (r_state == ST_XFER) && !wr_out_fifo_full_i && !wr_out_fifo_afull_i;
    assign w_own_valid = r_owner ? req1_valid_i : req0_valid_i;
    assign w_own_last  = r_owner ? req1_last_i  : req0_last_i;
    assign w_own_data  = r_owner ? req1_data_i  : req0_data_i;
    assign w_accept    = w_xfer_ok && w_own_valid;

    assign req0_ready_o = w_xfer_ok && !r_owner;
    assign req1_ready_o = w_xfer_ok &&  r_owner;

    // Watchdog counts only owner-idle cycles; FIFO stalls with valid high hold it.
    assign w_wd_inc    = r_wd_cnt + WD_W'(1);
    assign w_wd_expire = (r_state == ST_XFER) && !w_own_valid &&
                         (w_wd_inc == WD_W'(TIMEOUT_CYCLES));

    assign wr_out_fifo_clk_o  = clk_24576000_i;
    assign wr_out_fifo_en_o   = r_wr_en;
    assign wr_out_fifo_data_o = r_wr_data;
    assign timeout_o          = r_timeout;

    always_ff @(posedge clk_24576000_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_wd_cnt     <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_wr_en   <= w_accept;
            r_timeout <= 1'b0;
            if (w_accept) begin
                r_wr_data <= w_own_data;
            end
            case (r_state)
                ST_IDLE: begin
                    r_wd_cnt <= '0;
                    if (req0_valid_i || req1_valid_i) begin
                        r_state <= ST_XFER;
                        if (req0_valid_i && req1_valid_i) begin
                            r_owner <= ~r_last_owner;
                        end else begin
                            r_owner <= req1_valid_i;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
                        r_wd_cnt <= '0;
                        if (w_own_last) begin
                            r_last_owner <= r_owner;
                            r_state      <= ST_IDLE;
                        end
                    end else if (w_wd_expire) begin
                        r_timeout    <= 1'b1;
                        r_last_owner <= r_owner;
                        r_state      <= ST_IDLE;
                        r_wd_cnt     <= '0;
                    end else if (!w_own_valid) begin
                        r_wd_cnt <= w_wd_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef OUT_ARB_LEN_CHECK_EN
    localparam int unsigned LEN_W = 6;
    localparam int unsigned CNT_W = 7;

    logic             r_hdr_pend;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_pay_cnt;
    logic             r_len_err;
    logic [CNT_W-1:0] w_pay_next;
    logic [LEN_W-1:0] w_len_cur;

    // Payload count saturates so oversized packets can never wrap into a false match.
    assign w_pay_next = r_hdr_pend ? '0 :
                        (&r_pay_cnt) ? r_pay_cnt : r_pay_cnt + CNT_W'(1);
    assign w_len_cur  = r_hdr_pend ? w_own_data[LEN_W-1:0] : r_len;

    always_ff @(posedge clk_24576000_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hdr_pend <= 1'b1;
            r_len      <= '0;
            r_pay_cnt  <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            if (w_accept) begin
                if (r_hdr_pend) begin
                    r_len <= w_own_data[LEN_W-1:0];
                end
                r_pay_cnt  <= w_pay_next;
                r_hdr_pend <= w_own_last;
                if (w_own_last) begin
                    r_len_err <= (w_pay_next != CNT_W'(w_len_cur));
                end
            end else if (w_wd_expire) begin
                r_hdr_pend <= 1'b1;
            end
        end
    end

    assign len_err_o = r_len_err;
`else
    assign len_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_out_fifo_arbiter.sv
// Directed self-checking bench for out_fifo_arbiter: requester queues, FIFO write log, assertions.
`timescale 1ns/1ps
module tb_out_fifo_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0;
    logic       req0_ready, req1_ready;
    logic       fifo_clk, wr_en, timeout, len_err;
    logic [7:0] wr_data;
    logic       full, afull;

    int total = 0;
    int bad   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       acc0 = 1'b0, acc1 = 1'b0;
    int         cyc = 0;
    logic [7:0] wq[$];
    int         wcyc[$];
    int         acyc[$];
    int         to_cnt = 0, to_cyc = 0, le_cnt = 0, both_rdy = 0;
    logic       to_rdy = 1'b0;

    always #5 clk = ~clk;

    out_fifo_arbiter #(.TIMEOUT_CYCLES(255)) dut (
        .clk_24576000_i     (clk),
        .reset_n_i          (reset_n),
        .req0_valid_i       (req0_valid),
        .req0_data_i        (req0_data),
        .req0_last_i        (req0_last),
        .req0_ready_o       (req0_ready),
        .req1_valid_i       (req1_valid),
        .req1_data_i        (req1_data),
        .req1_last_i        (req1_last),
        .req1_ready_o       (req1_ready),
        .wr_out_fifo_clk_o  (fifo_clk),
        .wr_out_fifo_en_o   (wr_en),
        .wr_out_fifo_data_o (wr_data),
        .wr_out_fifo_full_i (full),
        .wr_out_fifo_afull_i(afull),
        .timeout_o          (timeout),
        .len_err_o          (len_err)
    );

    // Requester drivers: pop on a handshake seen last half-cycle, present the queue head.
    always @(posedge clk) begin
        #1;
        if (acc0 && q0.size() > 0) q0.delete(0);
        if (acc1 && q1.size() > 0) q1.delete(0);
        if (q0.size() > 0) begin
            req0_valid = 1'b1;
            {req0_last, req0_data} = q0[0];
        end else begin
            req0_valid = 1'b0;
            {req0_last, req0_data} = 9'h000;
        end
        if (q1.size() > 0) begin
            req1_valid = 1'b1;
            {req1_last, req1_data} = q1[0];
        end else begin
            req1_valid = 1'b0;
            {req1_last, req1_data} = 9'h000;
        end
    end

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        cyc++;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0 || acc1) acyc.push_back(cyc);
        if (wr_en) begin
            wq.push_back(wr_data);
            wcyc.push_back(cyc);
        end
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
            to_rdy = req0_ready || req1_ready;
        end
        if (len_err) le_cnt++;
        if (req0_ready && req1_ready) both_rdy++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_wr(input int n, input string tag);
        int k = 0;
        while (wq.size() < n && k < 2000) begin
            tick(1);
            k++;
        end
        chk({tag, "_wait"}, 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic clear_logs();
        wq.delete();
        wcyc.delete();
        acyc.delete();
    endtask

    initial begin
        int n;
        int k;
        int le_base;
        logic [7:0] exp28[8];
        logic [7:0] exp29[6];
        exp28 = '{8'h01, 8'hA1, 8'h01, 8'hB1, 8'h01, 8'hA2, 8'h01, 8'hB2};
        exp29 = '{8'h05, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};

        reset_n = 1'b0;
        full    = 1'b0;
        afull   = 1'b0;
        tick(3);
        chk("rst_en",      32'(wr_en),      32'd0);
        chk("rst_data",    32'(wr_data),    32'h00);
        chk("rst_timeout", 32'(timeout),    32'd0);
        chk("rst_lenerr",  32'(len_err),    32'd0);
        chk("rst_rdy0",    32'(req0_ready), 32'd0);
        chk("rst_rdy1",    32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("fifo_clk_hi", 32'(fifo_clk), 32'd1);
        tick(1);
        chk("fifo_clk_lo", 32'(fifo_clk), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Both requesters valid from reset: strict alternation, req0 first.
        q0.push_back(9'h001); q0.push_back(9'h1A1); q0.push_back(9'h001); q0.push_back(9'h1A2);
        q1.push_back(9'h001); q1.push_back(9'h1B1); q1.push_back(9'h001); q1.push_back(9'h1B2);
        wait_wr(8, "rr");
        tick(3);
        chk("rr_count", 32'(wq.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_byte%0d", i), 32'(wq[i]), 32'(exp28[i]));
        chk("rr_no_dual_ready", 32'(both_rdy), 32'd0);
        clear_logs();

        // Single packet latency: each write one cycle after its accept, back to back.
        q0.push_back(9'h041); q0.push_back(9'h1AB);
        wait_wr(2, "lat");
        tick(2);
        chk("lat_count", 32'(wq.size()), 32'd2);
        chk("lat_b0",    32'(wq[0]),     32'h41);
        chk("lat_b1",    32'(wq[1]),     32'hAB);
        chk("lat_acc0",  32'(wcyc[0] - acyc[0]), 32'd1);
        chk("lat_acc1",  32'(wcyc[1] - acyc[1]), 32'd1);
        chk("lat_consec", 32'(wcyc[1] - wcyc[0]), 32'd1);
        clear_logs();

        // Almost-full then full stalls mid-packet.
        q0.push_back(9'h005); q0.push_back(9'h0C1); q0.push_back(9'h0C2);
        q0.push_back(9'h0C3); q0.push_back(9'h0C4); q0.push_back(9'h1C5);
        wait_wr(2, "afull_pre");
        @(posedge clk);
        #2;
        afull = 1'b1;
        tick(1);
        n = wq.size();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(1);
            chk($sformatf("afull_rdy0_%0d", i), 32'(req0_ready), 32'd0);
            chk($sformatf("afull_rdy1_%0d", i), 32'(req1_ready), 32'd0);
        end
        chk("afull_no_write", 32'(wq.size()), 32'(n));
        @(posedge clk);
        #2;
        afull = 1'b0;
        wait_wr(4, "full_pre");
        @(posedge clk);
        #2;
        full = 1'b1;
        tick(1);
        n = wq.size();
        tick(2);
        chk("full_rdy0", 32'(req0_ready), 32'd0);
        chk("full_no_write", 32'(wq.size()), 32'(n));
        @(posedge clk);
        #2;
        full = 1'b0;
        wait_wr(6, "stall_done");
        tick(3);
        chk("stall_count", 32'(wq.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("stall_byte%0d", i), 32'(wq[i]), 32'(exp29[i]));
        clear_logs();

        // Req1 goes silent after its header; watchdog revokes and req0 takes over.
        q1.push_back(9'h002);
        wait_wr(1, "wd_hdr");
        q0.push_back(9'h001); q0.push_back(9'h1D1);
        k = 0;
        while (to_cnt == 0 && k < 400) begin
            tick(1);
            k++;
        end
        chk("wd_fired", 32'(to_cnt), 32'd1);
        chk("wd_delay", 32'(to_cyc - wcyc[0]), 32'd255);
        chk("wd_idle_rdy", 32'(to_rdy), 32'd0);
        wait_wr(3, "wd_next");
        tick(3);
        chk("wd_single_pulse", 32'(to_cnt), 32'd1);
        chk("wd_next_b0", 32'(wq[1]), 32'h01);
        chk("wd_next_b1", 32'(wq[2]), 32'hD1);
        chk("wd_no_lenerr", 32'(le_cnt), 32'd0);
        clear_logs();

        // Header length vs payload count.
        le_base = le_cnt;
        q0.push_back(9'h042); q0.push_back(9'h1E1);
        wait_wr(2, "len_bad");
        tick(3);
        chk("len_fwd_b0", 32'(wq[0]), 32'h42);
        chk("len_fwd_b1", 32'(wq[1]), 32'hE1);
`ifdef OUT_ARB_LEN_CHECK_EN
        chk("len_mismatch_pulse", 32'(le_cnt), 32'(le_base + 1));
`else
        chk("len_tied_low", 32'(le_cnt), 32'(le_base));
`endif
        le_base = le_cnt;
        q0.push_back(9'h041); q0.push_back(9'h1E2);
        wait_wr(4, "len_ok");
        tick(3);
        chk("len_match_quiet", 32'(le_cnt), 32'(le_base));
        clear_logs();

        // Reset mid-packet: abandon, no write after release, req0 wins the next tie.
        q0.push_back(9'h004); q0.push_back(9'h0F1); q0.push_back(9'h0F2);
        q0.push_back(9'h0F3); q0.push_back(9'h1F4);
        wait_wr(2, "mid_rst_pre");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("mid_rst_en",   32'(wr_en),      32'd0);
        chk("mid_rst_data", 32'(wr_data),    32'h00);
        chk("mid_rst_rdy0", 32'(req0_ready), 32'd0);
        tick(2);
        n = wq.size();
        reset_n = 1'b1;
        tick(2);
        chk("post_rst_no_write", 32'(wq.size()), 32'(n));
        le_base = le_cnt;
        q0.push_back(9'h001); q0.push_back(9'h15A);
        q1.push_back(9'h001); q1.push_back(9'h15B);
        wait_wr(n + 4, "post_rst_tie");
        tick(3);
        chk("post_rst_b0", 32'(wq[n]),     32'h01);
        chk("post_rst_b1", 32'(wq[n + 1]), 32'h5A);
        chk("post_rst_b2", 32'(wq[n + 2]), 32'h01);
        chk("post_rst_b3", 32'(wq[n + 3]), 32'h5B);
        chk("post_rst_lenerr", 32'(le_cnt), 32'(le_base));
        chk("final_no_dual_ready", 32'(both_rdy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
